mem_arbiter: RTL and testbench



---
 rtl/lc3b_types.sv | 13 +
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word, byte-enable mask and the memory arbiter FSM states.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single physical memory port.
// Define ARBITER_ROUND_ROBIN_EN for alternating tie-breaks; default build lets port 2 win every tie.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [ADDR_W-1:0] mem_addr1,
  input  logic              mem_read1,
  output logic [DATA_W-1:0] mem_rdata1,
  output logic              mem_resp1,

  input  logic [ADDR_W-1:0] mem_addr2,
  input  logic              mem_read2,
  input  logic              mem_write2,
  input  lc3b_mem_wmask     mem_wmask2,
  input  logic [DATA_W-1:0] mem_wdata2,
  output logic [DATA_W-1:0] mem_rdata2,
  output logic              mem_resp2,

  output logic [ADDR_W-1:0] pmem_addr,
  output logic              pmem_read,
  output logic              pmem_write,
  output lc3b_mem_wmask     pmem_wmask,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state;
  logic       sel2;
  logic       is_write;
  logic       req1;
  logic       req2;
  logic       grant2;

`ifdef ARBITER_ROUND_ROBIN_EN
  logic       last2;
`endif

  always_comb begin
    req1   = mem_read1;
    req2   = mem_read2 | mem_write2;
    grant2 = req2;
`ifdef ARBITER_ROUND_ROBIN_EN
    // on a tie, hand the grant to whichever port did not get it last time
    if (req1 && req2) grant2 = ~last2;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel2       <= 1'b0;
      is_write   <= 1'b0;
      pmem_addr  <= '0;
      pmem_wdata <= '0;
      pmem_wmask <= 2'b00;
      mem_rdata1 <= '0;
      mem_rdata2 <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
      last2      <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req1 || req2) begin
            sel2       <= grant2;
            is_write   <= grant2 & mem_write2;
            pmem_addr  <= grant2 ? mem_addr2 : mem_addr1;
            pmem_wmask <= (grant2 && mem_write2) ? mem_wmask2 : 2'b11;
            // port 1 has no write data, so the last value is simply kept
            if (grant2) pmem_wdata <= mem_wdata2;
`ifdef ARBITER_ROUND_ROBIN_EN
            last2      <= grant2;
`endif
            state      <= SERVE;
          end
        end
        SERVE: begin
          if (pmem_resp) begin
            if (!is_write) begin
              if (sel2) mem_rdata2 <= pmem_rdata;
              else      mem_rdata1 <= pmem_rdata;
            end
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign pmem_read  = (state == SERVE) && !is_write;
  assign pmem_write = (state == SERVE) &&  is_write;
  assign mem_resp1  = (state == RESP)  && !sel2;
  assign mem_resp2  = (state == RESP)  &&  sel2;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized request mixes
// checked against a transaction-level model of the two requesters and the memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mem_addr1, mem_rdata1;
  logic        mem_read1, mem_resp1;
  logic [15:0] mem_addr2, mem_wdata2, mem_rdata2;
  logic        mem_read2, mem_write2, mem_resp2;
  logic [1:0]  mem_wmask2, pmem_wmask;
  logic [15:0] pmem_addr, pmem_wdata, pmem_rdata;
  logic        pmem_read, pmem_write, pmem_resp;

  int vectors = 0;
  int miscompares = 0;

  // requester/memory model state
  bit          p1_pend, p2_pend, p2_rd, p2_wr;
  logic [15:0] p1_addr, p2_addr, p2_wdata;
  logic [1:0]  p2_mask;
  logic [15:0] exp_rd1, exp_rd2, last_addr;
  logic [1:0]  last_mask;
  int          last_grant;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_addr1  (mem_addr1),
    .mem_read1  (mem_read1),
    .mem_rdata1 (mem_rdata1),
    .mem_resp1  (mem_resp1),
    .mem_addr2  (mem_addr2),
    .mem_read2  (mem_read2),
    .mem_write2 (mem_write2),
    .mem_wmask2 (mem_wmask2),
    .mem_wdata2 (mem_wdata2),
    .mem_rdata2 (mem_rdata2),
    .mem_resp2  (mem_resp2),
    .pmem_addr  (pmem_addr),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_wmask (pmem_wmask),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    mem_read1  = p1_pend;
    mem_addr1  = p1_addr;
    mem_read2  = p2_pend && p2_rd;
    mem_write2 = p2_pend && p2_wr;
    mem_addr2  = p2_addr;
    mem_wdata2 = p2_wdata;
    mem_wmask2 = p2_mask;
  endtask

  task automatic model_reset();
    exp_rd1 = '0; exp_rd2 = '0; last_addr = '0; last_mask = 2'b00; last_grant = 2;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_pmem_read"},  pmem_read,  1'b0);
    chk({tag, "_pmem_write"}, pmem_write, 1'b0);
    chk({tag, "_resp1"},      mem_resp1,  1'b0);
    chk({tag, "_resp2"},      mem_resp2,  1'b0);
    chk({tag, "_addr_hold"},  pmem_addr,  last_addr);
    chk({tag, "_mask_hold"},  pmem_wmask, last_mask);
    chk({tag, "_rdata1"},     mem_rdata1, exp_rd1);
    chk({tag, "_rdata2"},     mem_rdata2, exp_rd2);
  endtask

  // Called in an idle cycle with requests already driven; returns in the following idle cycle.
  task automatic do_txn(input int w, input logic [15:0] rd);
    int          win;
    bit          ewr;
    logic [15:0] eaddr, ewd;
    logic [1:0]  emask;
    if (p1_pend && p2_pend) begin
`ifdef ARBITER_ROUND_ROBIN_EN
      win = (last_grant == 1) ? 2 : 1;
`else
      win = 2;
`endif
    end else begin
      win = p1_pend ? 1 : 2;
    end
    last_grant = win;
    ewr   = (win == 2) && p2_wr;
    eaddr = (win == 2) ? p2_addr : p1_addr;
    emask = ewr ? p2_mask : 2'b11;
    ewd   = p2_wdata;
    pmem_resp  = 1'($urandom_range(0, 1));
    pmem_rdata = 16'($urandom);
    tick();
    for (int i = 0; i <= w; i++) begin
      chk("serve_read",  pmem_read,  !ewr);
      chk("serve_write", pmem_write, ewr);
      chk("serve_addr",  pmem_addr,  eaddr);
      chk("serve_mask",  pmem_wmask, emask);
      if (ewr) chk("serve_wdata", pmem_wdata, ewd);
      chk("serve_resp1", mem_resp1, 1'b0);
      chk("serve_resp2", mem_resp2, 1'b0);
      // winner changes its address/data while still requesting; latched values must not move
      if (win == 1) begin
        mem_addr1 = 16'($urandom);
      end else begin
        mem_addr2  = 16'($urandom);
        mem_wdata2 = 16'($urandom);
        mem_wmask2 = 2'($urandom);
      end
      pmem_resp  = (i == w);
      pmem_rdata = (i == w) ? rd : 16'($urandom);
      tick();
    end
    if (!ewr) begin
      if (win == 1) exp_rd1 = rd;
      else          exp_rd2 = rd;
    end
    last_addr = eaddr;
    last_mask = emask;
    chk("resp_pulse1", mem_resp1, win == 1);
    chk("resp_pulse2", mem_resp2, win == 2);
    chk("resp_read",   pmem_read,  1'b0);
    chk("resp_write",  pmem_write, 1'b0);
    chk("resp_rdata1", mem_rdata1, exp_rd1);
    chk("resp_rdata2", mem_rdata2, exp_rd2);
    if (win == 1) p1_pend = 0;
    else          p2_pend = 0;
    drive_reqs();
    pmem_resp  = 1'($urandom_range(0, 1));
    pmem_rdata = 16'($urandom);
    tick();
    check_idle("post");
  endtask

  initial begin
    p1_pend = 0; p2_pend = 0; p2_rd = 0; p2_wr = 0;
    p1_addr = '0; p2_addr = '0; p2_wdata = '0; p2_mask = '0;
    model_reset();
    drive_reqs();
    pmem_resp = 0; pmem_rdata = '0;
    tick(); tick();
    chk("rst_read",  pmem_read,  1'b0);
    chk("rst_write", pmem_write, 1'b0);
    chk("rst_resp1", mem_resp1,  1'b0);
    chk("rst_resp2", mem_resp2,  1'b0);
    chk("rst_rdata1", mem_rdata1, 16'h0);
    chk("rst_rdata2", mem_rdata2, 16'h0);
    chk("rst_addr",  pmem_addr,  16'h0);
    chk("rst_wdata", pmem_wdata, 16'h0);
    chk("rst_wmask", pmem_wmask, 2'b00);
    rst_n = 1;

    // port-1 read with three wait cycles
    p1_pend = 1; p1_addr = 16'h0040; drive_reqs();
    do_txn(3, 16'h1234);
    chk("p1_read_data", mem_rdata1, 16'h1234);

    // back-to-back re-request right after the response
    p1_pend = 1; p1_addr = 16'h0042; drive_reqs();
    do_txn(0, 16'h5A5A);
    chk("b2b_data", mem_rdata1, 16'h5A5A);

    // port-2 write leaves read data untouched
    p2_pend = 1; p2_rd = 0; p2_wr = 1; p2_addr = 16'h0100; p2_wdata = 16'hBEEF; p2_mask = 2'b01;
    drive_reqs();
    do_txn(1, 16'hDEAD);
    chk("p2_write_rdata", mem_rdata2, 16'h0000);

    // read+write together is a write
    p2_pend = 1; p2_rd = 1; p2_wr = 1; p2_addr = 16'h0200; p2_wdata = 16'h0F0F; p2_mask = 2'b10;
    drive_reqs();
    do_txn(0, 16'h7777);

    // both ports requesting continuously
    for (int k = 0; k < 6; k++) begin
      if (!p1_pend) begin p1_pend = 1; p1_addr = 16'h1000 + 16'(k); end
      if (!p2_pend) begin p2_pend = 1; p2_rd = 1; p2_wr = 0; p2_addr = 16'h2000 + 16'(k); end
      drive_reqs();
      do_txn(0, 16'($urandom));
    end
    if (p1_pend || p2_pend) do_txn(0, 16'($urandom));

    // reset in the middle of a read
    p1_pend = 1; p1_addr = 16'h3333; drive_reqs();
    pmem_resp = 0;
    tick();
    chk("mid_pmem_read", pmem_read, 1'b1);
    rst_n = 0;
    tick();
    chk("mid_rst_read",  pmem_read,  1'b0);
    chk("mid_rst_write", pmem_write, 1'b0);
    chk("mid_rst_resp1", mem_resp1,  1'b0);
    chk("mid_rst_resp2", mem_resp2,  1'b0);
    rst_n = 1;
    model_reset();
    p1_pend = 0; drive_reqs();
    pmem_resp = 1; pmem_rdata = 16'hFFFF;
    tick();
    check_idle("late_resp");
    pmem_resp = 0;
    tick();
    check_idle("after_rst");

    // randomized request mixes
    for (int n = 0; n < 60; n++) begin
      if (!p1_pend && $urandom_range(0, 1) == 1) begin
        p1_pend = 1; p1_addr = 16'($urandom);
      end
      if (!p2_pend && $urandom_range(0, 1) == 1) begin
        int r;
        r = int'($urandom_range(0, 2));
        p2_pend = 1; p2_rd = (r != 1); p2_wr = (r != 0);
        p2_addr = 16'($urandom); p2_wdata = 16'($urandom); p2_mask = 2'($urandom);
      end
      drive_reqs();
      if (!p1_pend && !p2_pend) begin
        tick();
        check_idle("rand_idle");
      end else begin
        do_txn(int'($urandom_range(0, 3)), 16'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
